// File: rtl/bist_pkg.sv
// Shared types and the reference adder used by the adder BIST controller.
package bist_pkg;

  // Widest operand the reference adder supports.
  localparam int unsigned MaxWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StCheck,
    StDone
  } bist_state_t;

  // Returns {cout, s} of a + b + cin at MaxWidth; callers truncate to their width.
  function automatic logic [MaxWidth:0] golden_add(input logic [MaxWidth-1:0] a,
                                                   input logic [MaxWidth-1:0] b,
                                                   input logic                cin);
    return {1'b0, a} + {1'b0, b} + {{MaxWidth{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/adder_golden_model.sv
// Combinational reference sum {cout, s} for a Width-bit adder.
module adder_golden_model
  import bist_pkg::*;
#(
  parameter int unsigned Width = 1
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width:0]   sum_o
);

  assign sum_o = (Width + 1)'(golden_add(MaxWidth'(a_i), MaxWidth'(b_i), cin_i));

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive {a,b,cin} sweep over an external adder, checking each result against
// a reference sum; counts mismatches and captures the first failing vector.
module adder_bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned Width  = 1,
  parameter int unsigned Settle = 1,
  parameter int unsigned ErrW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  output logic [Width-1:0]     dut_a_o,
  output logic [Width-1:0]     dut_b_o,
  output logic                 dut_cin_o,
  input  logic [Width-1:0]     dut_s_i,
  input  logic                 dut_cout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [2*Width+1:0]   vec_count_o,
  output logic [ErrW-1:0]      err_count_o,
  output logic [2*Width:0]     first_err_o
);

  localparam int unsigned NvW   = 2 * Width + 1;
  localparam int unsigned WaitW = (Settle > 1) ? $clog2(Settle) : 1;

  bist_state_t      state_q, state_d;
  logic [NvW-1:0]   idx_q, idx_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [NvW:0]     vec_count_q, vec_count_d;
  logic [ErrW-1:0]  err_count_q, err_count_d;
  logic [NvW-1:0]   first_err_q, first_err_d;
  logic [Width:0]   golden;
  logic             mismatch;

  // The driven vector is decoded straight from the registered index.
  assign dut_a_o   = idx_q[NvW-1:Width+1];
  assign dut_b_o   = idx_q[Width:1];
  assign dut_cin_o = idx_q[0];

  adder_golden_model #(
    .Width(Width)
  ) u_golden (
    .a_i  (dut_a_o),
    .b_i  (dut_b_o),
    .cin_i(dut_cin_o),
    .sum_o(golden)
  );

  // Case inequality so an X/Z on the DUT side is reported as a mismatch.
  assign mismatch = ({dut_cout_i, dut_s_i} !== golden);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d     = StApply;
          idx_d       = '0;
          wait_d      = '0;
          vec_count_d = '0;
          err_count_d = '0;
          first_err_d = '0;
        end
      end
      StApply: begin
        if (wait_q == WaitW'(Settle - 1)) begin
          state_d = StCheck;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCheck: begin
        vec_count_d = vec_count_q + 1'b1;
        if (mismatch) begin
          if (err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (err_count_q == '0) begin
            first_err_d = idx_q;
          end
        end
        if (idx_q == '1) begin
          state_d = StDone;
        end else begin
          state_d = StApply;
          idx_d   = idx_q + 1'b1;
          wait_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      wait_q      <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign busy_o      = (state_q == StApply) || (state_q == StCheck);
  assign done_o      = (state_q == StDone);
  assign pass_o      = done_o && (err_count_q == '0);
  assign vec_count_o = vec_count_q;
  assign err_count_o = err_count_q;
  assign first_err_o = first_err_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: two instances (1-bit/settle 1, 4-bit/settle 2) driving
// fault-injectable behavioural adders; sweep results are checked by a scoreboard.
module tb_adder_bist_ctrl;

  typedef struct {
    int vec;
    int err;
    int first;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Instance 1: Width=1, Settle=1
  logic        start1;
  logic        a1, b1, cin1, s1, cout1;
  logic        busy1, done1, pass1;
  logic [3:0]  vc1;
  logic [31:0] ec1;
  logic [2:0]  fe1;
  int          mode1 = 0;
  logic [1:0]  sum1;

  // Instance 4: Width=4, Settle=2
  logic        start4;
  logic [3:0]  a4, b4, s4;
  logic        cin4, cout4;
  logic        busy4, done4, pass4;
  logic [9:0]  vc4;
  logic [31:0] ec4;
  logic [8:0]  fe4;
  int          mode4 = 0;
  logic [4:0]  sum4;

  exp_t q1[$];
  exp_t q4[$];

  adder_bist_ctrl #(.Width(1), .Settle(1), .ErrW(32)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start1),
    .dut_a_o    (a1),
    .dut_b_o    (b1),
    .dut_cin_o  (cin1),
    .dut_s_i    (s1),
    .dut_cout_i (cout1),
    .busy_o     (busy1),
    .done_o     (done1),
    .pass_o     (pass1),
    .vec_count_o(vc1),
    .err_count_o(ec1),
    .first_err_o(fe1)
  );

  adder_bist_ctrl #(.Width(4), .Settle(2), .ErrW(32)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start4),
    .dut_a_o    (a4),
    .dut_b_o    (b4),
    .dut_cin_o  (cin4),
    .dut_s_i    (s4),
    .dut_cout_i (cout4),
    .busy_o     (busy4),
    .done_o     (done4),
    .pass_o     (pass4),
    .vec_count_o(vc4),
    .err_count_o(ec4),
    .first_err_o(fe4)
  );

  // Adders under test: mode 0 correct, 1 sum stuck-at-0, 2 carry stuck-at-1.
  always_comb begin
    sum1  = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
    s1    = (mode1 == 1) ? 1'b0 : sum1[0];
    cout1 = (mode1 == 2) ? 1'b1 : sum1[1];
  end

  always_comb begin
    sum4  = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
    s4    = (mode4 == 1) ? 4'b0 : sum4[3:0];
    cout4 = (mode4 == 2) ? 1'b1 : sum4[4];
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic busy_of(input int inst);
    return (inst == 4) ? busy4 : busy1;
  endfunction

  function automatic logic done_of(input int inst);
    return (inst == 4) ? done4 : done1;
  endfunction

  function automatic int vec_of(input int inst);
    return (inst == 4) ? int'(vc4) : int'(vc1);
  endfunction

  // Scoreboard monitors: compare on every rising edge of done.
  logic done1_prev = 1'b0;
  logic done4_prev = 1'b0;

  always @(negedge clk) begin
    if (reset && done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL w1 unexpected done: got done=1 required no pending sweep");
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("w1 vec_count", vc1, e.vec);
        check("w1 err_count", ec1, e.err);
        check("w1 first_err", fe1, e.first);
        check("w1 pass", pass1, e.pass);
      end
    end
    done1_prev <= done1;
  end

  always @(negedge clk) begin
    if (reset && done4 && !done4_prev) begin
      if (q4.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL w4 unexpected done: got done=1 required no pending sweep");
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w4 vec_count", vc4, e.vec);
        check("w4 err_count", ec4, e.err);
        check("w4 first_err", fe4, e.first);
        check("w4 pass", pass4, e.pass);
      end
    end
    done4_prev <= done4;
  end

  // Runs one sweep; repulse >= 0 re-asserts start at that busy cycle.
  task automatic run_sweep(input int inst, input int mode, input int e_vec, input int e_err,
                           input int e_first, input int e_pass, input int e_busy,
                           input int repulse);
    exp_t e;
    int   cycles;
    e = '{vec: e_vec, err: e_err, first: e_first, pass: e_pass};
    if (inst == 4) begin
      mode4 = mode;
      q4.push_back(e);
    end else begin
      mode1 = mode;
      q1.push_back(e);
    end
    @(negedge clk);
    if (inst == 4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    check("sweep start busy", busy_of(inst), 1);
    check("sweep start done cleared", done_of(inst), 0);
    check("sweep start vec_count cleared", vec_of(inst), 0);
    cycles = 0;
    while (busy_of(inst) && cycles < 5000) begin
      cycles++;
      @(negedge clk);
      if (inst == 4) start4 = (cycles == repulse); else start1 = (cycles == repulse);
    end
    start1 = 1'b0;
    start4 = 1'b0;
    check("busy length", cycles, e_busy);
    check("done after sweep", done_of(inst), 1);
    @(negedge clk);
    check("scoreboard drained", (inst == 4) ? q4.size() : q1.size(), 0);
  endtask

  initial begin
    int cycles;
    // Reset held with start asserted: reset wins.
    reset  = 1'b0;
    start1 = 1'b1;
    start4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy1", busy1, 0);
    check("reset done1", done1, 0);
    check("reset pass1", pass1, 0);
    check("reset vec1", vc1, 0);
    check("reset err1", ec1, 0);
    check("reset vector1", {a1, b1, cin1}, 0);
    check("reset busy4", busy4, 0);
    check("reset done4", done4, 0);
    check("reset vector4", {a4, b4, cin4}, 0);
    start1 = 1'b0;
    start4 = 1'b0;
    reset  = 1'b1;
    @(negedge clk);

    run_sweep(1, 0, 8, 0, 0, 1, 16, -1);
    // Restart from DONE with a start pulse mid-sweep that must be ignored.
    run_sweep(1, 0, 8, 0, 0, 1, 16, 5);
    run_sweep(1, 1, 8, 4, 1, 0, 16, -1);
    run_sweep(1, 2, 8, 4, 0, 0, 16, -1);

    // Abort during APPLY of vector 5.
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cycles = 0;
    while ({a1, b1, cin1} != 3'd5 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check("abort reached vector 5", {a1, b1, cin1}, 5);
    check("abort vec_count before reset", vc1, 5);
    reset = 1'b0;
    @(negedge clk);
    check("abort busy", busy1, 0);
    check("abort done", done1, 0);
    check("abort vec_count", vc1, 0);
    check("abort err_count", ec1, 0);
    check("abort first_err", fe1, 0);
    check("abort vector", {a1, b1, cin1}, 0);
    reset = 1'b1;
    @(negedge clk);

    run_sweep(4, 0, 512, 0, 0, 1, 1536, -1);
    run_sweep(4, 2, 512, 256, 0, 0, 1536, -1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time exceeded budget");
    $fatal(1, "timeout");
  end

endmodule
